// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared types and constants for the unified I/D memory port
//                arbiter (state encoding, owner codes, default widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Owner of the access currently in flight
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_sat_counter
//  Description : Saturating up-counter with synchronous clear; o_full is
//                high while the count equals MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_full
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_cnt;

    // Count up to MAX and hold there; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_full = (r_cnt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single-port unified memory between instruction
//                fetch (I) and load/store (D). D has priority, I is forced
//                after STARVE_MAX consecutive D grants, and a hung access is
//                aborted with BusErr after TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic          IGnt,
    output logic          IValid,
    output logic [DW-1:0] IRdata,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWdata,
    output logic          DGnt,
    output logic          DValid,
    output logic [DW-1:0] DRdata,
    output logic          BusErr,
    output logic          MemEn,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemReady
);

    localparam int c_SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int c_TW = $clog2(TIMEOUT);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic          r_owner;
    logic          r_we;
    logic          r_gnt;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_irdata;
    logic [DW-1:0] r_drdata;

    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_hit;
    logic          w_abort;
    logic          w_starve_inc;
    logic          w_starve_clr;
    logic          w_starve_full;
    logic          w_tmo_inc;
    logic          w_tmo_full;

    // Consecutive D grants taken while a fetch was waiting
    arb_sat_counter #(
        .WIDTH (c_SW),
        .MAX   (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .i_clr  (w_starve_clr),
        .i_inc  (w_starve_inc),
        .o_full (w_starve_full)
    );

    // ACC cycles spent waiting for MemReady; full marks the last allowed cycle
    arb_sat_counter #(
        .WIDTH (c_TW),
        .MAX   (TIMEOUT - 1)
    ) u_tmo_cnt (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .i_clr  (w_grant_i | w_grant_d),
        .i_inc  (w_tmo_inc),
        .o_full (w_tmo_full)
    );

    // Next-state and arbitration decision
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_hit        = 1'b0;
        w_abort      = 1'b0;
        w_starve_inc = 1'b0;
        w_starve_clr = 1'b0;
        w_tmo_inc    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (DReq && !(IReq && w_starve_full)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ARB_ACC;
                end else if (IReq) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ARB_ACC;
                end
                w_starve_inc = w_grant_d && IReq;
                w_starve_clr = w_grant_i || !IReq;
            end
            ARB_ACC: begin
                if (MemReady) begin
                    w_hit       = 1'b1;
                    w_state_nxt = ARB_DONE;
                end else if (w_tmo_full) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ARB_DONE;
                end else begin
                    w_tmo_inc   = 1'b1;
                end
            end
            ARB_DONE: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Rst_n) r_state <= ARB_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Request latches, grant pulse, read-data capture and error flag
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_owner  <= OWNER_I;
            r_we     <= 1'b0;
            r_gnt    <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_irdata <= '0;
            r_drdata <= '0;
        end else begin
            r_gnt <= w_grant_i | w_grant_d;
            if (w_grant_d) begin
                r_owner <= OWNER_D;
                r_addr  <= DAddr;
                r_we    <= DWe;
                r_wdata <= DWdata;
                r_err   <= 1'b0;
            end else if (w_grant_i) begin
                r_owner <= OWNER_I;
                r_addr  <= IAddr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_err   <= 1'b0;
            end
            if (w_hit) begin
                // Stores leave the previous load data in place
                if (r_owner == OWNER_I) r_irdata <= MemRdata;
                else if (!r_we)         r_drdata <= MemRdata;
            end
            if (w_abort) begin
                r_err <= 1'b1;
                if (r_owner == OWNER_I) r_irdata <= '0;
                else                    r_drdata <= '0;
            end
        end
    end

    assign IGnt     = r_gnt && (r_owner == OWNER_I);
    assign DGnt     = r_gnt && (r_owner == OWNER_D);
    assign IValid   = (r_state == ARB_DONE) && (r_owner == OWNER_I);
    assign DValid   = (r_state == ARB_DONE) && (r_owner == OWNER_D);
    assign BusErr   = (r_state == ARB_DONE) && r_err;
    assign MemEn    = (r_state == ARB_ACC);
    assign MemWe    = MemEn && r_we;
    assign MemAddr  = r_addr;
    assign MemWdata = r_wdata;
    assign IRdata   = r_irdata;
    assign DRdata   = r_drdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A transaction-level
//                model predicts the winner of each arbitration, the memory
//                side request, completion timing and returned data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 64;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          IReq = 1'b0;
    logic [AW-1:0] IAddr = '0;
    logic          IGnt, IValid;
    logic [DW-1:0] IRdata;
    logic          DReq = 1'b0;
    logic          DWe = 1'b0;
    logic [AW-1:0] DAddr = '0;
    logic [DW-1:0] DWdata = '0;
    logic          DGnt, DValid;
    logic [DW-1:0] DRdata;
    logic          BusErr, MemEn, MemWe;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWdata;
    logic [DW-1:0] MemRdata = '0;
    logic          MemReady = 1'b0;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IRdata(IRdata),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
        .DGnt(DGnt), .DValid(DValid), .DRdata(DRdata), .BusErr(BusErr),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
        .MemRdata(MemRdata), .MemReady(MemReady)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int            m_starve = 0;
    bit            ipend = 1'b0;
    bit            dpend = 1'b0;
    logic [DW-1:0] m_irdata = '0;
    logic [DW-1:0] m_drdata = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Raise new requests (percent chance) on sides that are not already waiting
    task automatic new_reqs(input int pi, input int pd);
        if (!ipend && ($urandom_range(99) < pi)) begin
            ipend = 1'b1; IReq = 1'b1; IAddr = $urandom;
        end
        if (!dpend && ($urandom_range(99) < pd)) begin
            dpend = 1'b1; DReq = 1'b1; DAddr = $urandom;
            DWe = 1'($urandom_range(1)); DWdata = $urandom;
        end
    endtask

    task automatic drop_side(input bit side_d);
        if (side_d) begin dpend = 1'b0; DReq = 1'b0; end
        else        begin ipend = 1'b0; IReq = 1'b0; end
    endtask

    // One arbitration round, entered at the negedge of an IDLE cycle
    task automatic do_round(input int delay, input bit tmo, input bit drop_early,
                            input logic [DW-1:0] rdv);
        bit            win_d;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_wdata;
        int            nacc;
        if (!ipend && !dpend) begin
            @(posedge Clk); @(negedge Clk);
            check_val("idle_no_gnt", {61'd0, IGnt, DGnt, MemEn}, 64'd0);
            m_starve = 0;
            return;
        end
        win_d = dpend && !(ipend && (m_starve == SMAX));
        if (win_d && ipend) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else                m_starve = 0;
        e_addr  = win_d ? DAddr : IAddr;
        e_we    = win_d ? DWe : 1'b0;
        e_wdata = win_d ? DWdata : '0;

        @(posedge Clk); @(negedge Clk);
        check_val("gnt", {62'd0, IGnt, DGnt}, win_d ? 64'd1 : 64'd2);
        check_val("mem_addr", 64'(MemAddr), 64'(e_addr));
        check_val("mem_we", 64'(MemWe), 64'(e_we));
        check_val("mem_wdata", 64'(MemWdata), 64'(e_wdata));
        if (drop_early) drop_side(win_d);

        nacc = tmo ? TMO : delay + 1;
        for (int j = 0; j < nacc; j++) begin
            MemReady = !tmo && (j == delay);
            MemRdata = MemReady ? rdv : DW'($urandom);
            check_val("acc", {61'd0, MemEn, IValid, DValid}, 64'd4);
            if (j > 0) check_val("gnt_pulse", {62'd0, IGnt, DGnt}, 64'd0);
            @(posedge Clk); @(negedge Clk);
        end

        if (tmo) begin
            if (win_d) m_drdata = '0; else m_irdata = '0;
        end else if (!win_d) begin
            m_irdata = rdv;
        end else if (!e_we) begin
            m_drdata = rdv;
        end
        check_val("valid", {62'd0, IValid, DValid}, win_d ? 64'd1 : 64'd2);
        check_val("buserr", 64'(BusErr), 64'(tmo));
        check_val("done_memen", {62'd0, MemEn, IGnt | DGnt}, 64'd0);
        check_val("irdata", 64'(IRdata), 64'(m_irdata));
        check_val("drdata", 64'(DRdata), 64'(m_drdata));
        drop_side(win_d);
        // Stray ready/data outside ACC must be ignored
        MemReady = 1'($urandom_range(1));
        MemRdata = $urandom;
        @(posedge Clk); @(negedge Clk);
        check_val("idle_after", {60'd0, IValid, DValid, MemEn, BusErr}, 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_val("rst_ctl", {57'd0, IGnt, DGnt, IValid, DValid, BusErr, MemEn, MemWe}, 64'd0);
        check_val("rst_addr", 64'(MemAddr), 64'd0);
        check_val("rst_wdata", 64'(MemWdata), 64'd0);
        check_val("rst_rdata", {IRdata, DRdata}, 64'd0);
        Rst_n = 1'b1;

        // Single fetch, zero-wait memory
        ipend = 1'b1; IReq = 1'b1; IAddr = 32'h40;
        do_round(0, 1'b0, 1'b0, 32'h8C01_0004);

        // Simultaneous requests: D store wins, I follows
        ipend = 1'b1; IReq = 1'b1; IAddr = 32'h44;
        dpend = 1'b1; DReq = 1'b1; DWe = 1'b1; DAddr = 32'h100; DWdata = 32'hDEAD_BEEF;
        do_round(0, 1'b0, 1'b0, 32'h1111_2222);
        do_round(1, 1'b0, 1'b0, 32'h3333_4444);

        // Starvation: I held, D re-requested every round
        ipend = 1'b1; IReq = 1'b1; IAddr = 32'h48;
        for (int k = 0; k < 7; k++) begin
            new_reqs(0, 100);
            do_round(int'($urandom_range(2)), 1'b0, 1'b0, $urandom);
        end

        // Hung load times out, then a normal access
        drop_side(1'b0);
        dpend = 1'b1; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h200; DWdata = '0;
        do_round(0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        dpend = 1'b1; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h204;
        do_round(2, 1'b0, 1'b0, 32'h5555_AAAA);

        // Reset in the middle of an access
        ipend = 1'b1; IReq = 1'b1; IAddr = 32'h80;
        @(posedge Clk); @(negedge Clk);
        check_val("pre_rst_gnt", 64'(IGnt), 64'd1);
        Rst_n = 1'b0;
        @(posedge Clk); @(negedge Clk);
        Rst_n = 1'b1;
        drop_side(1'b0);
        m_irdata = '0; m_drdata = '0; m_starve = 0;
        check_val("midrst_ctl", {58'd0, IGnt, DGnt, IValid, DValid, BusErr, MemEn}, 64'd0);
        check_val("midrst_addr", 64'(MemAddr), 64'd0);
        check_val("midrst_rdata", {IRdata, DRdata}, 64'd0);
        @(posedge Clk); @(negedge Clk);
        check_val("midrst_novalid", {62'd0, IValid, DValid}, 64'd0);
        ipend = 1'b1; IReq = 1'b1; IAddr = 32'h84;
        do_round(1, 1'b0, 1'b0, 32'h0BAD_F00D);

        // Request dropped during ACC: completes once, no regrant
        ipend = 1'b1; IReq = 1'b1; IAddr = 32'h88;
        do_round(5, 1'b0, 1'b1, 32'h1234_5678);
        do_round(0, 1'b0, 1'b0, '0);

        // Randomized traffic
        for (int r = 0; r < 300; r++) begin
            new_reqs(50, 50);
            do_round(int'($urandom_range(4)), 1'b0, ($urandom_range(3) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
